// File: rtl/addr_resil_pkg.sv
// Shared types and mod-3 residue helpers for the pipelined fault-resilient adder.
package addr_resil_pkg;

    // Widest value the residue helper folds; covers WIDTH+1 up to 71 bits.
    localparam int MOD3_W = 72;

    // Control word travelling with each pipeline slot.
    typedef struct packed {
        logic       vld;
        logic       carry;
        logic [1:0] res;
    } stage_t;

    // Number of pipeline stages for a given operand and slice width.
    function automatic int nstage(input int width, input int stage_w);
        return width / stage_w;
    endfunction

    // (x + y) mod 3 for residues in 0..3 (3 is treated as 0).
    function automatic logic [1:0] add_mod3(input logic [1:0] x, input logic [1:0] y);
        logic [2:0] t;
        t = {1'b0, x} + {1'b0, y};
        return (t >= 3'd3) ? 2'(t - 3'd3) : t[1:0];
    endfunction

    // Unsigned residue mod 3: 4 == 1 (mod 3), so 2-bit digits can simply be summed.
    function automatic logic [1:0] mod3(input logic [MOD3_W-1:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < MOD3_W / 2; i++) begin
            r = add_mod3(r, v[2*i +: 2]);
        end
        return r;
    endfunction

endpackage

// File: rtl/addr_slice_stage.sv
// One STAGE_W-bit adder slice: adds slice IDX of A and B plus the incoming
// carry, merges it into the partial sum and registers everything.
module addr_slice_stage
    import addr_resil_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int STAGE_W = 8,
    parameter int IDX     = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  stage_t           ctl_i,
    input  logic [WIDTH:0]   sum_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output stage_t           ctl_o,
    output logic [WIDTH:0]   sum_o,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o
);

    localparam int LO   = IDX * STAGE_W;
    localparam bit LAST = ((LO + STAGE_W) == WIDTH);

    stage_t             ctl_d, ctl_q;
    logic [WIDTH:0]     sum_d, sum_q;
    logic [WIDTH-1:0]   a_d, a_q;
    logic [WIDTH-1:0]   b_d, b_q;
    logic [STAGE_W:0]   slice_sum;

    // Slice addition; the final stage also deposits the carry-out as the sum MSB.
    always_comb begin
        slice_sum = {1'b0, a_i[LO +: STAGE_W]} + {1'b0, b_i[LO +: STAGE_W]}
                  + {{STAGE_W{1'b0}}, ctl_i.carry};
        sum_d = sum_i;
        sum_d[LO +: STAGE_W] = slice_sum[STAGE_W-1:0];
        if (LAST) begin
            sum_d[WIDTH] = slice_sum[STAGE_W];
        end
        ctl_d       = ctl_i;
        ctl_d.carry = slice_sum[STAGE_W];
        a_d         = a_i;
        b_d         = b_i;
    end

    // Stage register; holds while the pipeline is stalled, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl_q <= '0;
            sum_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else if (en) begin
            ctl_q <= ctl_d;
            sum_q <= sum_d;
            a_q   <= a_d;
            b_q   <= b_d;
        end
    end

    assign ctl_o = ctl_q;
    assign sum_o = sum_q;
    assign a_o   = a_q;
    assign b_o   = b_q;

endmodule

// File: rtl/addr_u_pipe_resil.sv
// Pipelined unsigned adder with mod-3 residue fault check and a saturating
// fault counter, on a valid/ready stream. One STAGE_W slice per stage.
module addr_u_pipe_resil
    import addr_resil_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int STAGE_W = 8,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    output logic             out_fault,
    output logic [CNT_W-1:0] fault_cnt,
    input  logic             clr_cnt
);

    localparam int              NSTAGE  = nstage(WIDTH, STAGE_W);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    stage_t           ctl_p [0:NSTAGE];
    logic [WIDTH:0]   sum_p [0:NSTAGE];
    logic [WIDTH-1:0] a_p   [0:NSTAGE];
    logic [WIDTH-1:0] b_p   [0:NSTAGE];

    logic             en;
    logic [1:0]       res_in;
    logic [WIDTH:0]   res_sum;
    logic             inc;
    logic [CNT_W-1:0] fault_cnt_d, fault_cnt_q;

    // The whole pipeline advances together unless the consumer refuses a result.
    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;

    // Stage 0 input: operands, zero partial sum, and the expected residue of A+B.
    assign res_in   = add_mod3(mod3(MOD3_W'(in_a)), mod3(MOD3_W'(in_b)));
    assign ctl_p[0] = {in_valid, 1'b0, res_in};
    assign sum_p[0] = '0;
    assign a_p[0]   = in_a;
    assign b_p[0]   = in_b;

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        addr_slice_stage #(
            .WIDTH   (WIDTH),
            .STAGE_W (STAGE_W),
            .IDX     (k)
        ) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en),
            .ctl_i (ctl_p[k]),
            .sum_i (sum_p[k]),
            .a_i   (a_p[k]),
            .b_i   (b_p[k]),
            .ctl_o (ctl_p[k+1]),
            .sum_o (sum_p[k+1]),
            .a_o   (a_p[k+1]),
            .b_o   (b_p[k+1])
        );
    end

    // Output side: final sum and residue comparison against the carried r_in.
    assign res_sum   = sum_p[NSTAGE];
    assign out_sum   = res_sum;
    assign out_valid = ctl_p[NSTAGE].vld;
    assign out_fault = out_valid && (mod3(MOD3_W'(res_sum)) != ctl_p[NSTAGE].res);

    // Fault counter next state: saturating, a coincident clear keeps the new event.
    always_comb begin
        inc         = out_valid && out_ready && out_fault;
        fault_cnt_d = fault_cnt_q;
        if (clr_cnt) begin
            fault_cnt_d = inc ? CNT_W'(1) : '0;
        end else if (inc && (fault_cnt_q != CNT_MAX)) begin
            fault_cnt_d = fault_cnt_q + CNT_W'(1);
        end
    end

    // Fault counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_cnt_q <= '0;
        end else begin
            fault_cnt_q <= fault_cnt_d;
        end
    end

    assign fault_cnt = fault_cnt_q;

endmodule

// File: tb/tb_addr_u_pipe_resil.sv
// Bench for addr_u_pipe_resil: directed cases, a randomized stream against a
// queue-based reference, fault injection, counter saturation and mid-stream reset.
module tb_addr_u_pipe_resil;

    logic        clk;
    logic        rst_n;

    // Main instance: WIDTH=16, STAGE_W=8, CNT_W=8
    logic        in_valid, in_ready, out_valid, out_ready, out_fault, clr_cnt;
    logic [15:0] in_a, in_b;
    logic [16:0] out_sum;
    logic [7:0]  fault_cnt;

    // Second instance: WIDTH=8, STAGE_W=8 (single stage), CNT_W=2
    logic        c_valid, c_ready, c_ovalid, c_oready, c_fault, c_clr;
    logic [7:0]  c_a, c_b;
    logic [8:0]  c_sum;
    logic [1:0]  c_cnt;

    int          n_chk  = 0;
    int          n_pass = 0;

    logic [16:0] q_exp[$];
    int          n_out;
    bit          mon_en;
    bit          prev_stall;
    logic [16:0] prev_sum;
    logic        prev_fault;
    logic [16:0] frc_val;
    logic [8:0]  c_frc;

    addr_u_pipe_resil #(.WIDTH(16), .STAGE_W(8), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_fault (out_fault),
        .fault_cnt (fault_cnt),
        .clr_cnt   (clr_cnt)
    );

    addr_u_pipe_resil #(.WIDTH(8), .STAGE_W(8), .CNT_W(2)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (c_valid),
        .in_ready  (c_ready),
        .in_a      (c_a),
        .in_b      (c_b),
        .out_valid (c_ovalid),
        .out_ready (c_oready),
        .out_sum   (c_sum),
        .out_fault (c_fault),
        .fault_cnt (c_cnt),
        .clr_cnt   (c_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated transfer on the main instance; result expected two cycles later.
    task automatic send_one(input logic [15:0] a, input logic [15:0] b, input string tag);
        logic [16:0] e;
        e = {1'b0, a} + {1'b0, b};
        in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, "_early_vld"}, out_valid, 0);
        tick();
        chk({tag, "_vld"}, out_valid, 1);
        chk({tag, "_sum"}, out_sum, e);
        chk({tag, "_fault"}, out_fault, 0);
        tick();
        chk({tag, "_after_vld"}, out_valid, 0);
    endtask

    // Scoreboard: every accepted input must come out once, in order, with A+B.
    initial begin
        logic [16:0] e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (prev_stall) begin
                    chk("hold_sum", out_sum, prev_sum);
                    chk("hold_fault", out_fault, prev_fault);
                end
                chk("in_ready_vs_stall", in_ready, !(out_valid && !out_ready));
                if (in_valid && in_ready) begin
                    q_exp.push_back({1'b0, in_a} + {1'b0, in_b});
                end
                if (out_valid && out_ready) begin
                    chk("stream_no_extra", (q_exp.size() != 0), 1);
                    if (q_exp.size() != 0) begin
                        e = q_exp.pop_front();
                        chk("stream_sum", out_sum, e);
                        chk("stream_fault", out_fault, 0);
                        n_out++;
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_sum   = out_sum;
                prev_fault = out_fault;
            end
        end
    end

    initial begin
        logic [16:0] e0, e1, e2;
        logic        acc;
        int          cyc;
        int          exp_cnt;

        rst_n = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1; clr_cnt = 1'b0;
        c_valid = 1'b0; c_a = '0; c_b = '0; c_oready = 1'b1; c_clr = 1'b0;
        mon_en = 1'b0; prev_stall = 1'b0; prev_sum = '0; prev_fault = 1'b0; n_out = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_fault", out_fault, 0);
        chk("rst_fault_cnt", fault_cnt, 0);
        chk("rst_c_out_valid", c_ovalid, 0);
        chk("rst_c_cnt", c_cnt, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);

        // Directed cases
        send_one(16'h00FF, 16'h0001, "ff_plus_1");
        send_one(16'hFFFF, 16'hFFFF, "ones_plus_ones");
        send_one(16'hFF00, 16'h0100, "carry_out");
        send_one(16'h0000, 16'h0000, "zeros");

        // Randomized back-to-back stream with random backpressure
        mon_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            in_a = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            in_b = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            acc = 1'b0;
            cyc = 0;
            while (!acc && cyc < 1000) begin
                out_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                acc = in_ready;
                tick();
                cyc++;
            end
            if (!acc) chk("stream_accept_timeout", cyc, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 50 && q_exp.size() != 0; t++) tick();
        tick();
        chk("stream_drained", q_exp.size(), 0);
        chk("stream_count", n_out, 100);
        mon_en = 1'b0;

        // Fault injection on the middle result of three
        e0 = 17'h0 + 17'h1234 + 17'h0F0F;
        e1 = 17'h0 + 17'h80FF + 17'h7F01;
        e2 = 17'h0 + 17'h0A0A + 17'h0505;
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h0F0F;
        tick();
        in_a = 16'h80FF; in_b = 16'h7F01;
        tick();
        chk("inj_r0_sum", out_sum, e0);
        chk("inj_r0_fault", out_fault, 0);
        in_a = 16'h0A0A; in_b = 16'h0505;
        tick();
        in_valid = 1'b0;
        chk("inj_r1_sum_clean", out_sum, e1);
        frc_val = e1 ^ 17'h00100;
        force dut.res_sum = frc_val;
        #1;
        chk("inj_r1_fault", out_fault, 1);
        chk("inj_cnt_before", fault_cnt, 0);
        @(posedge clk);
        #1;
        release dut.res_sum;
        #1;
        chk("inj_r2_sum", out_sum, e2);
        chk("inj_r2_fault", out_fault, 0);
        chk("inj_cnt_after", fault_cnt, 1);
        tick();
        chk("inj_cnt_steady", fault_cnt, 1);
        chk("inj_drained", out_valid, 0);

        // Reset with two operands in flight
        in_valid = 1'b1; in_a = 16'h1111; in_b = 16'h2222;
        tick();
        in_a = 16'h3333; in_b = 16'h4444;
        tick();
        in_valid = 1'b0;
        chk("mid_vld_before_rst", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_vld_async", out_valid, 0);
        chk("mid_rst_sum", out_sum, 0);
        chk("mid_rst_cnt", fault_cnt, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tick();
            chk("mid_no_stale", out_valid, 0);
        end
        send_one(16'h0102, 16'h0304, "post_rst");

        // Single-stage instance: latency 1 and the all-ones case
        c_valid = 1'b1; c_a = 8'hFF; c_b = 8'hFF;
        tick();
        c_valid = 1'b0;
        chk("c_vld", c_ovalid, 1);
        chk("c_sum", c_sum, 9'h1FE);
        chk("c_fault", c_fault, 0);
        tick();
        chk("c_vld_after", c_ovalid, 0);

        // Counter saturation, then a clear coincident with a sixth fault
        exp_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            c_valid = 1'b1; c_a = 8'(i * 37); c_b = 8'h11;
            tick();
            c_valid = 1'b0;
            c_clr = (i == 5);
            c_frc = ({1'b0, c_a} + {1'b0, c_b}) ^ 9'h001;
            force dut2.res_sum = c_frc;
            #1;
            chk("sat_fault", c_fault, 1);
            @(posedge clk);
            #1;
            release dut2.res_sum;
            c_clr = 1'b0;
            if (i == 5) exp_cnt = 1;
            else if (exp_cnt < 3) exp_cnt = exp_cnt + 1;
            chk("sat_cnt", c_cnt, exp_cnt);
        end
        c_clr = 1'b1;
        tick();
        c_clr = 1'b0;
        chk("clr_alone", c_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
